mips_timer: RTL

- Memory-mapped countdown timer that responds to the word stores and loads issued by the MEM stage.
- Its inputs are driven from the MEM-stage address (ALU result), store data and 4-bit byte-enable carried by the EX/MEM pipeline register.
- Produces read data for the MEM-stage load mux and an interrupt request for the CP0 exception logic.
- Three registers: CTRL, PRESET, COUNT.

---
 rtl/mips_timer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer on the MEM-stage bus.
// Register map (word offsets from BASE_ADDR): +0 CTRL, +4 PRESET, +8 COUNT (RO), +C reserved.
// irq is raised when the countdown finishes and IM is set; one-shot clears EN,
// auto-reload keeps EN and emits a single-cycle irq pulse per period.
module mips_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
  parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_FIRE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q;

  logic        wr_acc_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        auto_reload_s;
  logic        cnt_done_s;
  logic        unused_s;

  // Only full-word stores that hit the block are accepted.
  assign hit           = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_acc_s      = hit && (byte_en == 4'hF);
  assign wr_ctrl_s     = wr_acc_s && (addr[3:2] == 2'd0);
  assign wr_preset_s   = wr_acc_s && (addr[3:2] == 2'd1);
  // MODE 1x behaves exactly like one-shot.
  assign auto_reload_s = (mode_q == 2'b01);
  // PRESET=0 loads 0 and is treated like 1 by this test.
  assign cnt_done_s    = (count_q <= 32'd1);
  assign unused_s      = ^{addr[1:0], wdata[31:4]};
  assign irq           = irq_q;

  // Current-state register of the countdown sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection of the countdown sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = en_q ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_CNT;
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (cnt_done_s) begin
          state_d = S_FIRE;
        end else begin
          state_d = S_CNT;
        end
      end
      S_FIRE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register updates driven by the sequencer, with CPU stores taking priority.
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    case (state_q)
      S_IDLE: begin
        count_d = count_q;
      end
      S_LOAD: begin
        count_d = preset_q;
      end
      S_CNT: begin
        if (en_q && cnt_done_s) begin
          count_d   = 32'd0;
          pending_d = 1'b1;
        end else if (en_q) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = count_q;
        end
      end
      S_FIRE: begin
        if (auto_reload_s) begin
          pending_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase

    if (wr_ctrl_s) begin
      en_d      = wdata[0];
      mode_d    = wdata[2:1];
      im_d      = wdata[3];
      pending_d = 1'b0;
    end else if (wr_preset_s) begin
      preset_d  = wdata;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_d;
    end
  end

  // Storage for CTRL, PRESET, COUNT, the pending flag and the registered irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      im_q      <= 1'b0;
      preset_q  <= RST_PRESET;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= pending_d & im_d;
    end
  end

  // Load-path read mux; misses and the reserved slot read as zero.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule
